// File: rtl/step_button_conditioner.sv
// Push-button to single-step clock: 2-flop sync, debounce FSM with optional auto-repeat, step shaper.
// press_pulse lands DEB_CYCLES+2 edges after the first sampled rise; pulses arriving while busy are dropped.
module step_button_conditioner #(
    parameter int unsigned DEB_CYCLES    = 1000000,
    parameter int unsigned STEP_HIGH     = 4,
    parameter bit          REPEAT_EN     = 1'b0,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000,
    parameter int unsigned CNT_W         = 27
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        button,
    output logic        btn_level,
    output logic        press_pulse,
    output logic        step_clk,
    output logic [15:0] step_count,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ARM, HELD, DISARM} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_FIRST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_NEXT   = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST  = CNT_W'(STEP_HIGH - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(STEP_HIGH);

    logic             s_meta, s;
    state_t           state, state_nxt;
    logic [CNT_W-1:0] deb_cnt, deb_nxt;
    logic [CNT_W-1:0] rep_cnt, rep_nxt;
    logic             rep_first, rep_first_nxt;
    logic             press_nxt;
    logic             rep_hit;
    logic [CNT_W-1:0] ph_cnt;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            s_meta <= 1'b0;
            s      <= 1'b0;
        end else begin
            s_meta <= button;
            s      <= s_meta;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state       <= IDLE;
            deb_cnt     <= '0;
            rep_cnt     <= '0;
            rep_first   <= 1'b1;
            press_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            deb_cnt     <= deb_nxt;
            rep_cnt     <= rep_nxt;
            rep_first   <= rep_first_nxt;
            press_pulse <= press_nxt;
        end
    end

    // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD; both count from zero.
    assign rep_hit = (rep_cnt == (rep_first ? REP_FIRST : REP_NEXT));

    always_comb begin
        state_nxt     = state;
        deb_nxt       = deb_cnt;
        rep_nxt       = rep_cnt;
        rep_first_nxt = rep_first;
        press_nxt     = 1'b0;
        case (state)
            IDLE: begin
                rep_nxt       = '0;
                rep_first_nxt = 1'b1;
                if (s) begin
                    state_nxt = ARM;
                    deb_nxt   = '0;
                end
            end
            ARM: begin
                if (!s) begin
                    state_nxt = IDLE;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt     = HELD;
                    press_nxt     = 1'b1;
                    rep_nxt       = '0;
                    rep_first_nxt = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_nxt = DISARM;
                    deb_nxt   = '0;
                end else if (REPEAT_EN) begin
                    if (rep_hit && !press_pulse) begin
                        press_nxt     = 1'b1;
                        rep_nxt       = '0;
                        rep_first_nxt = 1'b0;
                    end else if (!rep_hit) begin
                        rep_nxt = rep_cnt + CNT_W'(1);
                    end
                end
            end
            DISARM: begin
                // Repeat state is kept so a release bounce does not restart the delay.
                if (s) begin
                    state_nxt = HELD;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt     = IDLE;
                    rep_nxt       = '0;
                    rep_first_nxt = 1'b1;
                end else begin
                    deb_nxt = deb_cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign btn_level = (state == HELD) || (state == DISARM);

    // Low guard runs STEP_HIGH+1 cycles so busy drops one edge after the low phase completes.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            step_clk   <= 1'b0;
            busy       <= 1'b0;
            ph_cnt     <= '0;
            step_count <= 16'd0;
        end else if (!busy) begin
            if (press_pulse) begin
                step_clk   <= 1'b1;
                busy       <= 1'b1;
                ph_cnt     <= '0;
                step_count <= step_count + 16'd1;
            end
        end else if (step_clk) begin
            if (ph_cnt == HIGH_LAST) begin
                step_clk <= 1'b0;
                ph_cnt   <= '0;
            end else begin
                ph_cnt <= ph_cnt + CNT_W'(1);
            end
        end else begin
            if (ph_cnt == GUARD_LAST) begin
                busy   <= 1'b0;
                ph_cnt <= '0;
            end else begin
                ph_cnt <= ph_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_step_button_conditioner.sv
// Bench for step_button_conditioner: three instances (no repeat, repeat period 6, repeat period 3).
// Expected press pulses and step_clk rises are queued at stimulus time and matched by a negedge monitor.
module tb_step_button_conditioner;

    localparam int DEB = 8;
    localparam int SH  = 2;
    localparam int LAT = DEB + 2;

    logic        CLK   = 1'b0;
    logic        Reset = 1'b0;
    logic [2:0]  btn   = '0;
    logic [2:0]  lvl, pp, sclk, bsy;
    logic [47:0] cnt_all;

    typedef struct packed { int inst; int cyc; } ev_t;
    typedef struct { int bounces; int blen; int rbounces; int rblen; int lat; } press_vec_t;

    ev_t         pq[$];
    ev_t         rq[$];
    logic [15:0] exp_cnt [3];
    int          cyc   = 0;
    int          n_chk = 0;
    int          n_err = 0;
    logic [2:0]  prev_sclk = '0;
    int          hi_len [3];

    step_button_conditioner #(.DEB_CYCLES(DEB), .STEP_HIGH(SH), .REPEAT_EN(1'b0)) dut_a (
        .CLK(CLK), .Reset(Reset), .button(btn[0]), .btn_level(lvl[0]), .press_pulse(pp[0]),
        .step_clk(sclk[0]), .step_count(cnt_all[15:0]), .busy(bsy[0]));

    step_button_conditioner #(.DEB_CYCLES(DEB), .STEP_HIGH(SH), .REPEAT_EN(1'b1),
                              .REPEAT_DELAY(20), .REPEAT_PERIOD(6)) dut_b (
        .CLK(CLK), .Reset(Reset), .button(btn[1]), .btn_level(lvl[1]), .press_pulse(pp[1]),
        .step_clk(sclk[1]), .step_count(cnt_all[31:16]), .busy(bsy[1]));

    step_button_conditioner #(.DEB_CYCLES(DEB), .STEP_HIGH(SH), .REPEAT_EN(1'b1),
                              .REPEAT_DELAY(20), .REPEAT_PERIOD(3)) dut_c (
        .CLK(CLK), .Reset(Reset), .button(btn[2]), .btn_level(lvl[2]), .press_pulse(pp[2]),
        .step_clk(sclk[2]), .step_count(cnt_all[47:32]), .busy(bsy[2]));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] get_cnt(input int k);
        return cnt_all[k*16 +: 16];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge CLK);
    endtask

    // Press/release on instance A; final rise is first sampled at edge e.
    task automatic press_a(input int bounces, input int blen, input int rbounces,
                           input int rblen, input int lat, input bit shape, input string tag);
        int e, r;
        for (int i = 0; i < bounces; i++) begin
            btn[0] = 1'b1; tick(blen);
            btn[0] = 1'b0; tick(blen);
        end
        btn[0] = 1'b1;
        e = cyc + 1;
        pq.push_back(ev_t'{inst: 0, cyc: e + lat});
        rq.push_back(ev_t'{inst: 0, cyc: e + lat + 1});
        exp_cnt[0] = exp_cnt[0] + 16'd1;
        wait_until(e + lat - 1);
        chk({tag, " level before accept"}, lvl[0], 1'b0);
        tick(1);
        chk({tag, " level on accept"}, lvl[0], 1'b1);
        if (shape) begin
            wait_until(e + lat + 1);
            chk({tag, " step_clk high 1"}, sclk[0], 1'b1);
            chk({tag, " busy on rise"}, bsy[0], 1'b1);
            wait_until(e + lat + 2);
            chk({tag, " step_clk high 2"}, sclk[0], 1'b1);
            wait_until(e + lat + 3);
            chk({tag, " step_clk low"}, sclk[0], 1'b0);
            chk({tag, " busy in guard"}, bsy[0], 1'b1);
            wait_until(e + lat + 5);
            chk({tag, " busy guard end"}, bsy[0], 1'b1);
            wait_until(e + lat + 6);
            chk({tag, " busy cleared"}, bsy[0], 1'b0);
        end
        wait_until(e + lat + 10);
        for (int i = 0; i < rbounces; i++) begin
            btn[0] = 1'b0; tick(rblen);
            btn[0] = 1'b1; tick(rblen);
            chk({tag, " level held through release bounce"}, lvl[0], 1'b1);
        end
        btn[0] = 1'b0;
        r = cyc + 1;
        wait_until(r + lat - 1);
        chk({tag, " level before release"}, lvl[0], 1'b1);
        tick(1);
        chk({tag, " level after release"}, lvl[0], 1'b0);
        tick(4);
        chk({tag, " step_count"}, get_cnt(0), exp_cnt[0]);
        chk({tag, " busy idle"}, bsy[0], 1'b0);
    endtask

    // Auto-repeat hold: HELD lasts 50 cycles, busy window per step is 2*SH+2 cycles from the pulse.
    task automatic rep_test(input int k, input int period, input int exp_steps, input string tag);
        int e, h, p, free;
        btn[k] = 1'b1;
        e = cyc + 1;
        h = e + LAT;
        p = h;
        free = 0;
        while (p <= h + 49) begin
            pq.push_back(ev_t'{inst: k, cyc: p});
            if (p >= free) begin
                rq.push_back(ev_t'{inst: k, cyc: p + 1});
                free = p + 2 * SH + 2;
            end
            p = (p == h) ? h + 20 : p + period;
        end
        wait_until(h + 1);
        chk({tag, " level held"}, lvl[k], 1'b1);
        wait_until(h + 47);
        btn[k] = 1'b0;
        wait_until(h + 48 + LAT + 2);
        chk({tag, " level released"}, lvl[k], 1'b0);
        chk({tag, " busy idle"}, bsy[k], 1'b0);
        chk({tag, " step_count"}, get_cnt(k), exp_steps);
    endtask

    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (Reset) begin
                prev_sclk = '0;
                for (int k = 0; k < 3; k++) hi_len[k] = 0;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    if (pp[k]) begin
                        n_chk++;
                        if (pq.size() > 0 && pq[0].inst == k && pq[0].cyc == cyc) begin
                            void'(pq.pop_front());
                        end else begin
                            n_err++;
                            $display("FAIL press_pulse[%0d]: pulse at edge %0d, none expected there", k, cyc);
                        end
                    end
                    if (sclk[k] && !prev_sclk[k]) begin
                        n_chk++;
                        if (rq.size() > 0 && rq[0].inst == k && rq[0].cyc == cyc) begin
                            void'(rq.pop_front());
                        end else begin
                            n_err++;
                            $display("FAIL step_clk[%0d] rise: at edge %0d, none expected there", k, cyc);
                        end
                    end
                    if (!sclk[k] && prev_sclk[k]) begin
                        n_chk++;
                        if (hi_len[k] != SH) begin
                            n_err++;
                            $display("FAIL step_clk[%0d] high width: got %0d, expected %0d", k, hi_len[k], SH);
                        end
                    end
                    hi_len[k]    = sclk[k] ? hi_len[k] + 1 : 0;
                    prev_sclk[k] = sclk[k];
                end
            end
            while (pq.size() > 0 && pq[0].cyc < cyc) begin
                n_chk++; n_err++;
                $display("FAIL press_pulse[%0d]: missing, required at edge %0d", pq[0].inst, pq[0].cyc);
                void'(pq.pop_front());
            end
            while (rq.size() > 0 && rq[0].cyc < cyc) begin
                n_chk++; n_err++;
                $display("FAIL step_clk[%0d] rise: missing, required at edge %0d", rq[0].inst, rq[0].cyc);
                void'(rq.pop_front());
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : main
        press_vec_t tbl [4];
        int e, r;
        tbl[0] = '{0, 0, 0, 0, LAT};
        tbl[1] = '{2, 3, 2, 3, LAT};
        tbl[2] = '{1, 5, 1, 7, LAT};
        tbl[3] = '{3, 1, 1, 1, LAT};
        for (int k = 0; k < 3; k++) begin
            exp_cnt[k] = 16'd0;
            hi_len[k]  = 0;
        end

        #1 Reset = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            chk("reset btn_level", lvl[k], 1'b0);
            chk("reset press_pulse", pp[k], 1'b0);
            chk("reset step_clk", sclk[k], 1'b0);
            chk("reset busy", bsy[k], 1'b0);
            chk("reset step_count", get_cnt(k), 16'd0);
        end
        @(negedge CLK);
        #1 Reset = 1'b0;
        tick(2);

        press_a(0, 0, 0, 0, LAT, 1'b1, "clean press");

        for (int i = 0; i < 4; i++)
            press_a(tbl[i].bounces, tbl[i].blen, tbl[i].rbounces, tbl[i].rblen,
                    tbl[i].lat, 1'b0, $sformatf("vec%0d", i));

        rep_test(1, 6, 6, "repeat period 6");
        rep_test(2, 3, 6, "repeat period 3");

        // Reset during a step high phase, button kept down.
        btn[0] = 1'b1;
        e = cyc + 1;
        pq.push_back(ev_t'{inst: 0, cyc: e + LAT});
        rq.push_back(ev_t'{inst: 0, cyc: e + LAT + 1});
        wait_until(e + LAT + 1);
        chk("pre-reset step_clk", sclk[0], 1'b1);
        #1 Reset = 1'b1;
        #1;
        chk("mid-step reset step_clk", sclk[0], 1'b0);
        chk("mid-step reset busy", bsy[0], 1'b0);
        chk("mid-step reset btn_level", lvl[0], 1'b0);
        chk("mid-step reset step_count", get_cnt(0), 16'd0);
        chk("mid-step reset count B", get_cnt(1), 16'd0);
        @(negedge CLK);
        #1 Reset = 1'b0;
        e = cyc + 1;
        pq.push_back(ev_t'{inst: 0, cyc: e + LAT});
        rq.push_back(ev_t'{inst: 0, cyc: e + LAT + 1});
        exp_cnt[0] = 16'd1;
        wait_until(e + LAT - 1);
        chk("post-reset level before debounce", lvl[0], 1'b0);
        tick(1);
        chk("post-reset level accepted", lvl[0], 1'b1);
        wait_until(e + LAT + 8);
        chk("post-reset step_count", get_cnt(0), exp_cnt[0]);
        btn[0] = 1'b0;
        r = cyc + 1;
        wait_until(r + LAT + 2);
        chk("post-reset release", lvl[0], 1'b0);

        // Counter wrap.
        @(negedge CLK);
        force dut_a.step_count = 16'hFFFF;
        tick(1);
        release dut_a.step_count;
        tick(1);
        chk("preload step_count", get_cnt(0), 16'hFFFF);
        exp_cnt[0] = 16'hFFFF;
        press_a(0, 0, 0, 0, LAT, 1'b1, "wrap press");

        tick(5);
        chk("pulse queue drained", pq.size(), 0);
        chk("rise queue drained", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/step_button_conditioner.md
Name: step_button_conditioner

Overview:
- Conditions the raw Basys3 push-button into the single-step clock that drives the single-cycle CPU.
- Sits directly upstream of the CPU step clock input and the display refresh logic.
- Synchronises the button, debounces it with a state machine, and emits a one-cycle press pulse.
- Shapes that pulse into a fixed-width step clock, with optional hold-to-auto-repeat.

Parameters:
- DEB_CYCLES, 1000000: consecutive stable CLK cycles required to accept a press or a release (10 ms at 100 MHz); must be >= 2.
- STEP_HIGH, 4: CLK cycles step_clk is held high per step; step_clk is then held low for at least STEP_HIGH cycles.
- REPEAT_EN, 0: 1 enables auto-repeat while the button is held.
- REPEAT_DELAY, 50000000: cycles in HELD before the first repeat pulse.
- REPEAT_PERIOD, 10000000: cycles between subsequent repeat pulses; must be >= 2*STEP_HIGH.
- CNT_W, 27: width of internal counters; must hold the largest of the three count parameters.

Ports:
- CLK  input  1  system clock, 100 MHz
- Reset  input  1  asynchronous, active-high reset
- button  input  1  raw asynchronous push-button level, active-high
- btn_level  output  1  debounced button level
- press_pulse  output  1  one-CLK pulse per accepted press or repeat
- step_clk  output  1  shaped step clock to the CPU
- step_count  output  16  number of step_clk rising edges since reset; wraps 0xFFFF->0x0000
- busy  output  1  high while step_clk is in its high phase or low-guard phase

Behaviour:
- Reset (async assert, sync release): sync FFs = 0, FSM = IDLE, all counters = 0, all outputs = 0.
- Synchroniser: two-flop chain on button; output s. FSM uses only s.
- FSM states:
  - IDLE: btn_level = 0. If s = 1, go to ARM with counter cleared.
  - ARM: if s = 0, return to IDLE (bounce rejected). If s = 1, increment the counter. When the counter reaches DEB_CYCLES-1 with s = 1, go to HELD and register press_pulse = 1 on the same edge.
  - HELD: btn_level = 1. If s = 0, go to DISARM with counter cleared. Repeat logic runs only in this state.
  - DISARM: if s = 1, return to HELD (repeat counter NOT reset). If s = 0, count; at DEB_CYCLES-1, go to IDLE.
- Press latency: with a clean rise first sampled at edge 0, press_pulse is high exactly in the cycle after edge DEB_CYCLES+2. Release latency to btn_level = 0 is the same.
- btn_level changes on the HELD entry edge and the IDLE-from-DISARM edge.
- press_pulse: high for exactly 1 cycle, and never on two consecutive cycles.
- Auto-repeat (REPEAT_EN = 1):
  - The repeat counter clears on HELD entry.
  - A pulse fires when the counter reaches REPEAT_DELAY-1; the counter then reloads so later pulses come every REPEAT_PERIOD cycles.
  - Leaving HELD for IDLE clears the counter.
  - When REPEAT_EN = 0, only the press edge produces a pulse.
- Step shaper:
  - On press_pulse while busy = 0: step_clk rises on the next edge, stays high STEP_HIGH cycles, then stays low STEP_HIGH cycles (busy = 1 throughout both phases).
  - step_count increments on the edge where step_clk rises.
  - press_pulse while busy = 1 is dropped: no step, no count. press_pulse itself is still output.
- Simultaneous events: s falls on the same cycle the ARM counter terminates → IDLE, no pulse (s = 0 has priority).
- Reset mid-step: step_clk drops immediately (asynchronous), and step_count clears to 0.

Test Plan:
1. DEB_CYCLES=8, STEP_HIGH=2. Clean press, first sampled at edge 0 → press_pulse high only after edge 10; step_clk high after edges 11–12, low from edge 13; busy clears after edge 16; step_count = 1.
2. Bounce: button toggles 1,0,1,0 every 3 cycles, then stays 1 → exactly one press_pulse, issued 8+2 edges after the final rise; step_count = 1. A release bouncing for < 8 cycles keeps btn_level = 1.
3. REPEAT_EN=1, REPEAT_DELAY=20, REPEAT_PERIOD=6, hold 50 cycles after acceptance → pulses at HELD+0, +20, +26, +32, +38, +44; step_count = 6.
4. REPEAT_PERIOD=3 with STEP_HIGH=2 (illegal, used as a stress case) → pulses arriving during busy are dropped; step_count counts only accepted steps; step_clk high phases are never shorter than 2 cycles.
5. Assert Reset during a step_clk high phase → step_clk, busy, btn_level and step_count read 0 before the next CLK edge. After release with button still held, a new press is accepted only after DEB_CYCLES.
6. Preload 0xFFFF steps (force step_count), then one press → step_count = 0x0000, step_clk pulses normally.
